// File: rtl/out_stream_buffer_if.sv
// Handshake bundle between the uut result producer, the output FIFO and the host.
// The slave modport is the FIFO side. The master modport is the producer/host side.
interface out_stream_buffer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4
);
    // valid/ready: a word moves on a rising edge where the sender's valid and the
    // receiver's ready (enable_out on the write side, ready_in on the read side) are both 1.
    logic                       valid_in;
    logic [DATA_WIDTH-1:0]      din;
    logic                       enable_out;
    logic                       valid_out;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       ready_in;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;

    modport slave (
        input  valid_in, din, ready_in,
        output enable_out, valid_out, dout, count, overflow
    );

    modport master (
        output valid_in, din, ready_in,
        input  enable_out, valid_out, dout, count, overflow
    );
endinterface

// File: rtl/out_stream_buffer.sv
// First-word-fall-through FIFO carrying uut results to the host side of the shell.
// Words offered while full are dropped, and the drop is latched in a sticky overflow flag.
module out_stream_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    out_stream_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic w_enable;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_enable = (r_count < CW'(DEPTH));
    assign w_valid  = (r_count != '0);
    // A pop in the same cycle does not free space for a push: no bypass.
    assign w_push   = bus.valid_in && w_enable;
    assign w_pop    = w_valid && bus.ready_in;
    assign w_drop   = bus.valid_in && !w_enable;

    // Storage is not reset. Its contents stay invisible while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.enable_out = w_enable;
    assign bus.valid_out  = w_valid;
    assign bus.dout       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_out_stream_buffer.sv
// Directed bench for out_stream_buffer: expected words go into a queue when issued,
// and a negedge monitor pops and compares them on every accepted output handshake.
module tb_out_stream_buffer;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    out_stream_buffer_if #(.DATA_WIDTH(W), .DEPTH(DEPTH)) bus ();

    out_stream_buffer #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got dout 0x%0h, required no output", bus.dout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    n_errors++;
                    $display("FAIL sb_dout: got 0x%0h, required 0x%0h", bus.dout, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit accept, input bit rdy);
        bus.valid_in = 1'b1;
        bus.din      = d;
        bus.ready_in = rdy;
        if (accept) exp_q.push_back(d);
        step();
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        repeat (n) step();
        bus.ready_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.din      = '0;
        bus.ready_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();

        // Reset then idle
        check("rst_valid_out",  bus.valid_out,  0);
        check("rst_dout",       bus.dout,       0);
        check("rst_enable_out", bus.enable_out, 1);
        check("rst_count",      bus.count,      0);
        check("rst_overflow",   bus.overflow,   0);

        // Three words held, then drained in order
        push_word(32'hA1, 1'b1, 1'b0);
        check("lat_valid_out", bus.valid_out, 1);
        check("lat_dout",      bus.dout,      32'hA1);
        push_word(32'hA2, 1'b1, 1'b0);
        push_word(32'hA3, 1'b1, 1'b0);
        check("three_count", bus.count, 3);
        step();
        check("stall_dout", bus.dout, 32'hA1);
        drain(3);
        check("drain_valid_out", bus.valid_out, 0);
        check("drain_count",     bus.count,     0);
        check("drain_dout",      bus.dout,      0);

        // Fill past full: fifth word dropped
        for (int i = 1; i <= 4; i++) push_word(W'(i), 1'b1, 1'b0);
        check("full_count",      bus.count,      4);
        check("full_enable_out", bus.enable_out, 0);
        check("full_no_ovf",     bus.overflow,   0);
        push_word(32'h5, 1'b0, 1'b0);
        check("drop_count",    bus.count,    4);
        check("drop_overflow", bus.overflow, 1);
        drain(4);
        check("drain4_count", bus.count,    0);
        check("ovf_sticky",   bus.overflow, 1);

        // Streaming with count held at 2; pointers wrap several times
        push_word(32'h100, 1'b1, 1'b0);
        push_word(32'h101, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_word(W'(32'h102 + i), 1'b1, 1'b1);
            check("stream_count", bus.count, 2);
        end
        drain(2);
        check("stream_end_count", bus.count, 0);

        // Full FIFO with simultaneous push and pop: pop wins, push dropped
        do_reset();
        check("rst2_overflow", bus.overflow, 0);
        for (int i = 0; i < 4; i++) push_word(W'(32'h20 + i), 1'b1, 1'b0);
        push_word(32'h9, 1'b0, 1'b1);
        check("fullpp_count",    bus.count,    3);
        check("fullpp_overflow", bus.overflow, 1);
        check("fullpp_head",     bus.dout,     32'h21);

        // Asynchronous reset mid-cycle with three words queued
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid_out",  bus.valid_out,  0);
        check("arst_count",      bus.count,      0);
        check("arst_enable_out", bus.enable_out, 1);
        check("arst_overflow",   bus.overflow,   0);
        step();
        rst = 1'b1;
        step();
        push_word(32'h77, 1'b1, 1'b0);
        check("post_rst_valid", bus.valid_out, 1);
        check("post_rst_dout",  bus.dout,      32'h77);
        check("post_rst_count", bus.count,     1);
        drain(1);
        step();

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/out_stream_buffer.md
OUT_STREAM_BUFFER -- requirements
Module: out_stream_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 512, width of every data word.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 valid_in  input  1  producer (uut_interface write side) presents a word this cycle.
REQ-006 din  input  DATA_WIDTH  write data, sampled when valid_in=1.
REQ-007 enable_out  output  1  space available; producer may assert valid_in this cycle.
REQ-008 valid_out  output  1  dout holds a valid word for the host.
REQ-009 dout  output  DATA_WIDTH  head-of-queue word.
REQ-010 ready_in  input  1  host accepts dout this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky flag: a word was dropped because the queue was full.

Function
REQ-013 Block SHALL be a first-word-fall-through FIFO carrying uut results to the host side of the shell.
REQ-014 enable_out SHALL equal (count < DEPTH), combinational from registered count.
REQ-015 Push SHALL occur on a rising edge where valid_in=1 and enable_out=1; din written at wr_ptr, wr_ptr incremented.
REQ-016 valid_out SHALL equal (count != 0); dout SHALL equal the entry at rd_ptr when valid_out=1, else all zeros.
REQ-017 Pop SHALL occur on a rising edge where valid_out=1 and ready_in=1; rd_ptr incremented.
REQ-018 ready_in while valid_out=0 SHALL have no effect.
REQ-019 Latency: a word pushed into an empty FIFO at edge N SHALL appear on dout with valid_out=1 after edge N (visible in cycle N+1).
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra logic.
REQ-021 count SHALL update as: +1 push only, -1 pop only, unchanged on push+pop or neither.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL both complete; count unchanged, order preserved.
REQ-023 When full, enable_out=0; valid_in=1 SHALL be dropped (no write, no pointer move) even if a pop occurs the same cycle; no same-cycle bypass.
REQ-024 A dropped word SHALL set overflow=1 at that edge; overflow SHALL remain 1 until reset.
REQ-025 Data order SHALL be strict FIFO; no word duplicated or lost except per REQ-023.
REQ-026 dout and valid_out SHALL stay stable while valid_out=1 and ready_in=0.

Reset
REQ-027 rst=0 SHALL immediately, without clock, force wr_ptr=0, rd_ptr=0, count=0, overflow=0, hence valid_out=0, dout=0, enable_out=1.
REQ-028 Storage array SHALL NOT be reset; contents are unobservable after reset because count=0.
REQ-029 Reset asserted mid-transfer SHALL discard all queued words; the first push after rst returns to 1 SHALL be the first word out.
REQ-030 Push/pop SHALL NOT occur on the edge at which rst is still 0.

Verification
REQ-031 Reset then idle -> valid_out=0, dout=0, enable_out=1, count=0, overflow=0.
REQ-032 Push 0xA1, 0xA2, 0xA3 (ready_in=0), then ready_in=1 for 3 cycles -> dout 0xA1, 0xA2, 0xA3 in order, then valid_out=0, count=0.
REQ-033 DEPTH=4: push 5 words 0x1..0x5 with ready_in=0 -> count=4, enable_out=0 after 4th, 0x5 dropped, overflow=1; drain yields 0x1..0x4.
REQ-034 count=2, valid_in=1 and ready_in=1 every cycle for 10 cycles with incrementing data -> count stays 2, output sequence contiguous, pointers wrap cleanly.
REQ-035 Full FIFO, push 0x9 with simultaneous pop -> pop completes, 0x9 dropped, count=3, overflow=1.
REQ-036 count=3, assert rst=0 asynchronously mid-cycle -> valid_out=0, count=0 immediately; release, push 0x77 -> dout=0x77 next cycle.
